// File: rtl/pipe_mult_fu_pkg.sv
// Shared types for the pipelined RV32M multiply functional unit.
// The optional stall counter is enabled by MULT_FU_STALL_CNT_EN (see pipe_mult_fu.sv).
package pipe_mult_fu_pkg;

  typedef enum logic [1:0] {
    MULT_MUL    = 2'b00,
    MULT_MULH   = 2'b01,
    MULT_MULHSU = 2'b10,
    MULT_MULHU  = 2'b11
  } mult_func_e;

  function automatic logic rs1_is_signed(input mult_func_e f);
    return f != MULT_MULHU;
  endfunction

  function automatic logic rs2_is_signed(input mult_func_e f);
    return (f == MULT_MUL) || (f == MULT_MULH);
  endfunction

endpackage

// File: rtl/pipe_mult_fu_stage.sv
// One pipeline slot: adds SLICE partial products into the accumulator and registers
// the op. Data only loads with a valid op, so a bubble leaves the previous result visible.
module pipe_mult_fu_stage
  import pipe_mult_fu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SLICE = 8,
  parameter int TAG_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic              i_kill,
  input  logic              i_valid,
  input  mult_func_e        i_func,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [2*XLEN-1:0] i_mcand,
  input  logic [XLEN-1:0]   i_mplier,
  input  logic [2*XLEN-1:0] i_acc,
  output logic              o_valid,
  output mult_func_e        o_func,
  output logic [TAG_W-1:0]  o_tag,
  output logic [2*XLEN-1:0] o_mcand,
  output logic [XLEN-1:0]   o_mplier,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] w_pp;
  logic              r_valid;
  mult_func_e        r_func;
  logic [TAG_W-1:0]  r_tag;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [2*XLEN-1:0] r_acc;

  always_comb begin
    w_pp = '0;
    for (int j = 0; j < SLICE; j++) begin
      if (i_mplier[j]) w_pp = w_pp + (i_mcand << j);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_func   <= MULT_MUL;
      r_tag    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_func   <= i_func;
        r_tag    <= i_tag;
        r_mcand  <= i_mcand << SLICE;
        r_mplier <= i_mplier >> SLICE;
        r_acc    <= i_acc + w_pp;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_func   = r_func;
  assign o_tag    = r_tag;
  assign o_mcand  = r_mcand;
  assign o_mplier = r_mplier;
  assign o_acc    = r_acc;

endmodule

// File: rtl/pipe_mult_fu.sv
// Fully pipelined RV32M multiply FU with done/ack result hold toward the CDB.
// Define MULT_FU_STALL_CNT_EN to add the saturating stall_cycles counter output.
module pipe_mult_fu
  import pipe_mult_fu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [XLEN-1:0]  rs1_value,
  input  logic [XLEN-1:0]  rs2_value,
  input  logic [1:0]       func,
  input  logic [TAG_W-1:0] rob_tag,
  input  logic             clear,
  input  logic             ack,
  output logic             done,
  output logic [XLEN-1:0]  v,
  output logic [TAG_W-1:0] out_rob_tag
`ifdef MULT_FU_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int DIV   = (NUM_STAGES >= 1) ? NUM_STAGES : 1;
  localparam int SLICE = XLEN / DIV;
  localparam bit PARAMS_OK = (NUM_STAGES >= 1) && (NUM_STAGES <= 8) && (XLEN >= 1) &&
                             (TAG_W >= 1) && ((XLEN % DIV) == 0);

  if (!PARAMS_OK) begin : g_bad_params
    $fatal(1, "pipe_mult_fu: illegal XLEN/NUM_STAGES/TAG_W combination");
  end

  logic              w_advance;
  mult_func_e        w_func_in;
  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_acc0;

  logic [NUM_STAGES:0] w_valid;
  mult_func_e          w_func   [NUM_STAGES+1];
  logic [TAG_W-1:0]    w_tag    [NUM_STAGES+1];
  logic [2*XLEN-1:0]   w_mcand  [NUM_STAGES+1];
  logic [XLEN-1:0]     w_mplier [NUM_STAGES+1];
  logic [2*XLEN-1:0]   w_acc    [NUM_STAGES+1];

  assign w_func_in = mult_func_e'(func);

  // Only XLEN multiplier bits are summed; a negative signed rs2 is corrected by
  // preloading the accumulator with -(a_ext << XLEN).
  always_comb begin
    w_a_ext = rs1_is_signed(w_func_in) ? {{XLEN{rs1_value[XLEN-1]}}, rs1_value}
                                       : {{XLEN{1'b0}}, rs1_value};
    w_acc0  = '0;
    if (rs2_is_signed(w_func_in) && rs2_value[XLEN-1]) w_acc0 = -(w_a_ext << XLEN);
  end

  assign w_valid[0]  = issue_valid;
  assign w_func[0]   = w_func_in;
  assign w_tag[0]    = rob_tag;
  assign w_mcand[0]  = w_a_ext;
  assign w_mplier[0] = rs2_value;
  assign w_acc[0]    = w_acc0;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    pipe_mult_fu_stage #(
      .XLEN  (XLEN),
      .SLICE (SLICE),
      .TAG_W (TAG_W)
    ) u_stage (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_en     (w_advance),
      .i_kill   (clear),
      .i_valid  (w_valid[g]),
      .i_func   (w_func[g]),
      .i_tag    (w_tag[g]),
      .i_mcand  (w_mcand[g]),
      .i_mplier (w_mplier[g]),
      .i_acc    (w_acc[g]),
      .o_valid  (w_valid[g+1]),
      .o_func   (w_func[g+1]),
      .o_tag    (w_tag[g+1]),
      .o_mcand  (w_mcand[g+1]),
      .o_mplier (w_mplier[g+1]),
      .o_acc    (w_acc[g+1])
    );
  end

  // The last stage register doubles as the output holding register.
  assign done        = w_valid[NUM_STAGES];
  assign w_advance   = !done || ack;
  assign issue_ready = w_advance;
  assign out_rob_tag = w_tag[NUM_STAGES];
  assign v = (w_func[NUM_STAGES] == MULT_MUL) ? w_acc[NUM_STAGES][XLEN-1:0]
                                              : w_acc[NUM_STAGES][2*XLEN-1:XLEN];

  logic w_unused;
  assign w_unused = ^{w_mcand[NUM_STAGES], w_mplier[NUM_STAGES]};

`ifdef MULT_FU_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if (done && !ack && !clear && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
